// File: rtl/down_scale_win_gen_if.sv
// Pixel-in / column-out bundle of the 15x20 downscale window generator.
// line[k] of down_scale_con_line is column pixel k (0 = top row of the band).
interface down_scale_win_gen_if;
   logic             pix_valid;
   logic             pix_sof;
   logic [7:0]       pix_data;
   logic             down_scale_con_valid;
   logic [14:0][7:0] down_scale_con_line;
   logic             frame_done;
   logic             win_err;

   modport master (
      output pix_valid, pix_sof, pix_data,
      input  down_scale_con_valid, down_scale_con_line, frame_done, win_err
   );

   modport slave (
      input  pix_valid, pix_sof, pix_data,
      output down_scale_con_valid, down_scale_con_line, frame_done, win_err
   );
endinterface

// File: rtl/down_scale_win_gen.sv
// Buffers 14 rows of a raster stream and emits 15-pixel vertical columns on each band's last row.
// Optional framing check enabled by defining DS_WIN_CHECK_EN (win_err tied low otherwise).
module down_scale_win_gen #(
   parameter int IMG_WIDTH  = 640,
   parameter int IMG_HEIGHT = 480,
   parameter int COL_W      = 10
) (
   input  logic                  clk,
   input  logic                  rst_n,
   down_scale_win_gen_if.slave   ds_io
);

   localparam int NUM_BANDS = IMG_HEIGHT / 15;
   localparam int BAND_W    = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1;
   localparam int ADDR_W    = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
   localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(IMG_WIDTH - 1);
   localparam logic [BAND_W-1:0] LAST_BAND = BAND_W'(NUM_BANDS - 1);
   localparam logic [3:0]        EMIT_ROW  = 4'd14;

   logic [COL_W-1:0]  col_q,  col_d,  eff_col_s;
   logic [3:0]        brow_q, brow_d, eff_brow_s;
   logic [BAND_W-1:0] band_q, band_d, eff_band_s;
   logic [ADDR_W-1:0] addr_s;
   logic              emit_s;
   logic              wr_s;
   logic              last_pix_s;

   logic              valid_q;
   logic              frame_done_q;
   logic [14:0][7:0]  line_q;
   logic [7:0]        mem_q [14][IMG_WIDTH];

   // A qualified sof pixel is position (band 0, row 0, col 0) whatever the counters say.
   always_comb begin
      if (ds_io.pix_sof) begin
         eff_col_s  = '0;
         eff_brow_s = 4'd0;
         eff_band_s = '0;
      end else begin
         eff_col_s  = col_q;
         eff_brow_s = brow_q;
         eff_band_s = band_q;
      end
   end

   assign addr_s     = eff_col_s[ADDR_W-1:0];
   assign emit_s     = ds_io.pix_valid & (eff_brow_s == EMIT_ROW);
   assign wr_s       = ds_io.pix_valid & (eff_brow_s != EMIT_ROW);
   assign last_pix_s = emit_s & (eff_band_s == LAST_BAND) & (eff_col_s == LAST_COL);

   // Next raster position after the current pixel.
   always_comb begin
      col_d  = col_q;
      brow_d = brow_q;
      band_d = band_q;
      if (ds_io.pix_valid) begin
         brow_d = eff_brow_s;
         band_d = eff_band_s;
         if (eff_col_s == LAST_COL) begin
            col_d = '0;
            if (eff_brow_s == EMIT_ROW) begin
               brow_d = 4'd0;
               if (eff_band_s == LAST_BAND) begin
                  band_d = '0;
               end else begin
                  band_d = eff_band_s + BAND_W'(1);
               end
            end else begin
               brow_d = eff_brow_s + 4'd1;
            end
         end else begin
            col_d = eff_col_s + COL_W'(1);
         end
      end else begin
         col_d  = col_q;
         brow_d = brow_q;
         band_d = band_q;
      end
   end

   // Raster position counters.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         col_q  <= '0;
         brow_q <= 4'd0;
         band_q <= '0;
      end else begin
         col_q  <= col_d;
         brow_q <= brow_d;
         band_q <= band_d;
      end
   end

   // Line memories hold rows 0..13 of the current band; contents are never reset.
   always_ff @(posedge clk) begin
      if (rst_n && wr_s) begin
         mem_q[eff_brow_s][addr_s] <= ds_io.pix_data;
      end
   end

   // Column output: synchronous read of 14 rows plus the live pixel, one clock after input.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_q      <= 1'b0;
         frame_done_q <= 1'b0;
         line_q       <= '0;
      end else begin
         valid_q      <= emit_s;
         frame_done_q <= last_pix_s;
         if (emit_s) begin
            for (int k = 0; k < 14; k++) begin
               line_q[k] <= mem_q[k][addr_s];
            end
            line_q[14] <= ds_io.pix_data;
         end
      end
   end

   assign ds_io.down_scale_con_valid = valid_q;
   assign ds_io.down_scale_con_line  = line_q;
   assign ds_io.frame_done           = frame_done_q;

`ifdef DS_WIN_CHECK_EN
   logic at_origin_s;
   logic err_set_s;
   logic fd_seen_q;
   logic err_q;

   assign at_origin_s = (col_q == '0) & (brow_q == 4'd0) & (band_q == '0);
   // sof away from origin = truncated frame; missing sof at origin only counts once a frame completed.
   assign err_set_s   = ds_io.pix_valid &
                        (ds_io.pix_sof ? ~at_origin_s : (at_origin_s & fd_seen_q));

   // Sticky framing error and "a frame has completed" flag.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fd_seen_q <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         if (last_pix_s) begin
            fd_seen_q <= 1'b1;
         end
         if (err_set_s) begin
            err_q <= 1'b1;
         end
      end
   end

   assign ds_io.win_err = err_q;
`else
   assign ds_io.win_err = 1'b0;
`endif

endmodule
